// File: rtl/conv_window_seq_if.sv
// Pixel handshake, frame control and status bundle for conv_window_seq.
// stall_cnt exists only when CONV_WINDOW_SEQ_STALL_CNT_EN is defined.
interface conv_window_seq_if #(
  parameter int DIM_W = 10
);
  logic             start;
  logic [DIM_W-1:0] cfg_width;
  logic [DIM_W-1:0] cfg_height;
  logic             pixel_in_valid;
  logic             pixel_in_ready;
  logic             win_ready;
  logic             acc_clear;
  logic             out_valid;
  logic             busy;
  logic             frame_done;
  logic             cfg_err;
  logic [1:0]       current_state;
`ifdef CONV_WINDOW_SEQ_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  modport master (
    output start, cfg_width, cfg_height, pixel_in_valid,
    input  pixel_in_ready, win_ready, acc_clear, out_valid, busy,
           frame_done, cfg_err, current_state
`ifdef CONV_WINDOW_SEQ_STALL_CNT_EN
    , stall_cnt
`endif
  );

  modport slave (
    input  start, cfg_width, cfg_height, pixel_in_valid,
    output pixel_in_ready, win_ready, acc_clear, out_valid, busy,
           frame_done, cfg_err, current_state
`ifdef CONV_WINDOW_SEQ_STALL_CNT_EN
    , stall_cnt
`endif
  );
endinterface

// File: rtl/conv_window_seq.sv
// 3x3 convolution window sequencer: raster pixel counting, window strobes, MAC drain.
// Optional stall counter enabled by defining CONV_WINDOW_SEQ_STALL_CNT_EN.
//
// state | meaning
// IDLE  | waiting for a start with a valid (>=3x3) config
// LOAD  | filling the first two rows + two pixels; no windows yet
// RUN   | every accepted pixel at row>=2, col>=2 completes a window
// DRAIN | input closed, flushing PIPE_LAT MAC stages before frame_done
module conv_window_seq #(
  parameter int PIPE_LAT = 2,
  parameter int DIM_W    = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  conv_window_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [DIM_W-1:0] D1 = DIM_W'(1);
  localparam logic [DIM_W-1:0] D2 = DIM_W'(2);
  localparam logic [DIM_W-1:0] D3 = DIM_W'(3);
  localparam logic [2:0]       DRAIN_LD = 3'(PIPE_LAT);

  state_t              state_q, state_d;
  logic [DIM_W-1:0]    width_q, width_d, height_q, height_d;
  logic [DIM_W-1:0]    col_q, col_d, row_q, row_d;
  logic                win_q, win_d, done_q, done_d, err_q, err_d;
  logic [2:0]          drain_q, drain_d;
  logic [PIPE_LAT-1:0] dly_q, dly_d;

  logic in_ready, accept, cfg_ok, start_seen, start_acc, at_last, win_pos;

  assign in_ready   = (state_q == LOAD) || (state_q == RUN);
  assign accept     = bus.pixel_in_valid & in_ready;
  assign cfg_ok     = (bus.cfg_width >= D3) && (bus.cfg_height >= D3);
  // A start coinciding with the frame_done pulse is deliberately ignored.
  assign start_seen = (state_q == IDLE) && bus.start && !done_q;
  assign start_acc  = start_seen && cfg_ok;
  assign at_last    = (row_q == height_q - D1) && (col_q == width_q - D1);
  assign win_pos    = (row_q >= D2) && (col_q >= D2);

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    col_d    = col_q;
    row_d    = row_q;
    drain_d  = drain_q;
    err_d    = err_q;
    win_d    = 1'b0;
    done_d   = 1'b0;
    dly_d    = dly_q << 1;
    dly_d[0] = win_q;

    case (state_q)
      IDLE: begin
        if (start_acc) begin
          width_d  = bus.cfg_width;
          height_d = bus.cfg_height;
          col_d    = '0;
          row_d    = '0;
          err_d    = 1'b0;
          state_d  = LOAD;
        end else if (start_seen) begin
          err_d = 1'b1;
        end
      end
      LOAD, RUN: begin
        if (accept) begin
          win_d = win_pos;
          if (col_q == width_q - D1) begin
            col_d = '0;
            row_d = row_q + D1;
          end else begin
            col_d = col_q + D1;
          end
          // A 3x3 frame's first window is also its last pixel: go straight to DRAIN.
          if (at_last) begin
            state_d = DRAIN;
            drain_d = DRAIN_LD;
          end else if (state_q == LOAD && row_q == D2 && col_q == D2) begin
            state_d = RUN;
          end
        end
      end
      DRAIN: begin
        if (drain_q == 3'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      drain_q  <= '0;
      err_q    <= 1'b0;
      win_q    <= 1'b0;
      done_q   <= 1'b0;
      dly_q    <= '0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      col_q    <= col_d;
      row_q    <= row_d;
      drain_q  <= drain_d;
      err_q    <= err_d;
      win_q    <= win_d;
      done_q   <= done_d;
      dly_q    <= dly_d;
    end
  end

`ifdef CONV_WINDOW_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (in_ready && !bus.pixel_in_valid && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`endif

  assign bus.pixel_in_ready = in_ready;
  assign bus.win_ready      = win_q;
  assign bus.acc_clear      = ~win_q;
  assign bus.out_valid      = dly_q[PIPE_LAT-1];
  assign bus.busy           = (state_q != IDLE);
  assign bus.frame_done     = done_q;
  assign bus.cfg_err        = err_q;
  assign bus.current_state  = state_q;

endmodule

// File: tb/tb_conv_window_seq.sv
// Directed bench for conv_window_seq: exact frame timing, bad config, stalls,
// mid-frame reset and back-to-back start around frame_done.
module tb_conv_window_seq;
  localparam int PIPE_LAT = 2;
  localparam int DIM_W    = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  conv_window_seq_if #(.DIM_W(DIM_W)) bus();

  conv_window_seq #(.PIPE_LAT(PIPE_LAT), .DIM_W(DIM_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int c0 = 0;
  int win_log[$];
  int ov_log[$];
  int done_log[$];
  int n_acc, first_acc, last_acc;
  int ac_bad = 0, ov_bad = 0, busy_bad = 0;
  int ov_at_reset;
  logic [1:0] st_at [0:63];
  logic       rdy_at [0:63];
  logic [PIPE_LAT-1:0] hist = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle observer: event logs relative to the start cycle, plus invariants.
  always @(negedge clk) begin
    int idx;
    idx = cyc - c0;
    if (!reset_n) begin
      hist = '0;
    end else begin
      if (bus.acc_clear !== ~bus.win_ready) ac_bad++;
      if (bus.out_valid !== hist[PIPE_LAT-1]) ov_bad++;
      hist = {hist[PIPE_LAT-2:0], bus.win_ready};
      if (bus.busy !== (bus.current_state != 2'd0)) busy_bad++;
      if (idx >= 0 && idx < 64) begin
        st_at[idx]  = bus.current_state;
        rdy_at[idx] = bus.pixel_in_ready;
      end
      if (bus.win_ready)  win_log.push_back(idx);
      if (bus.out_valid)  ov_log.push_back(idx);
      if (bus.frame_done) done_log.push_back(idx);
      if (bus.pixel_in_valid && bus.pixel_in_ready) begin
        if (n_acc == 0) first_acc = idx;
        last_acc = idx;
        n_acc++;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    win_log.delete();
    ov_log.delete();
    done_log.delete();
    n_acc = 0;
    first_acc = -1;
    last_acc = -1;
    for (int i = 0; i < 64; i++) begin
      st_at[i]  = 2'd0;
      rdy_at[i] = 1'b0;
    end
  endtask

  // Start is high in cycle 0; returns 1ns into cycle 1.
  task automatic do_start(input int w, input int h, input bit hold);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.cfg_width  = DIM_W'(w);
    bus.cfg_height = DIM_W'(h);
    c0 = cyc;
    clear_logs();
    @(posedge clk); #1;
    if (!hold) begin
      bus.start      = 1'b0;
      bus.cfg_width  = DIM_W'(7);
      bus.cfg_height = DIM_W'(7);
    end
  endtask

  // mode 0: valid held high; mode 1: valid high on odd frame cycles only.
  task automatic run_frame(input int mode, input int n_done, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      bus.pixel_in_valid = (mode == 0) ? 1'b1 : 1'(((cyc - c0) % 2) == 1);
      @(negedge clk); #1;
      if (done_log.size() >= n_done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("frame_timeout", done_log.size(), n_done);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, bus.current_state, 0);
    chk({tag, "_ready"}, bus.pixel_in_ready, 0);
    chk({tag, "_win"},   bus.win_ready, 0);
    chk({tag, "_ov"},    bus.out_valid, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.frame_done, 0);
    chk({tag, "_acclr"}, bus.acc_clear, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.cfg_width = '0;
    bus.cfg_height = '0;
    bus.pixel_in_valid = 1'b0;
    clear_logs();

    // Reset values
    #12;
    chk_reset_outputs("rst");
    chk("rst_err", bus.cfg_err, 0);
    #10 reset_n = 1'b1;

    // 4x4 frame, valid held high, exact cycle timing
    do_start(4, 4, 1'b0);
    run_frame(0, 1, 60);
    chk("t1_nacc", n_acc, 16);
    chk("t1_first_acc", first_acc, 1);
    chk("t1_last_acc", last_acc, 16);
    chk("t1_nwin", win_log.size(), 4);
    chk("t1_win0", win_log[0], 12);
    chk("t1_win1", win_log[1], 13);
    chk("t1_win2", win_log[2], 16);
    chk("t1_win3", win_log[3], 17);
    chk("t1_nov", ov_log.size(), 4);
    chk("t1_ov0", ov_log[0], 14);
    chk("t1_ov1", ov_log[1], 15);
    chk("t1_ov2", ov_log[2], 18);
    chk("t1_ov3", ov_log[3], 19);
    chk("t1_done", done_log[0], 20);
    chk("t1_st11", st_at[11], 1);
    chk("t1_st12", st_at[12], 2);
    chk("t1_st17", st_at[17], 3);
    chk("t1_st19", st_at[19], 3);
    chk("t1_st20", st_at[20], 0);
    chk("t1_rdy16", rdy_at[16], 1);
    chk("t1_rdy17", rdy_at[17], 0);

    // Bad config rejected, then minimal 3x3 frame
    do_start(2, 8, 1'b0);
    chk("t2_bad_state", bus.current_state, 0);
    chk("t2_bad_busy", bus.busy, 0);
    chk("t2_bad_err", bus.cfg_err, 1);
    do_start(3, 3, 1'b0);
    chk("t2_err_clr", bus.cfg_err, 0);
    run_frame(0, 1, 60);
    chk("t2_nwin", win_log.size(), 1);
    chk("t2_win0", win_log[0], 10);
    chk("t2_nacc", n_acc, 9);
    chk("t2_done", done_log[0], 13);

    // 5x3 with valid toggling: counters must freeze on low cycles
    do_start(5, 3, 1'b0);
    run_frame(1, 1, 100);
    chk("t3_nacc", n_acc, 15);
    chk("t3_last_acc", last_acc, 29);
    chk("t3_nwin", win_log.size(), 3);
    chk("t3_win0", win_log[0], 26);
    chk("t3_win1", win_log[1], 28);
    chk("t3_win2", win_log[2], 30);
    chk("t3_nov", ov_log.size(), 3);
    chk("t3_done", done_log[0], 33);

    // Reset during RUN of an 8x8 frame, then a clean 8x8 frame
    bus.pixel_in_valid = 1'b1;
    do_start(8, 8, 1'b0);
    repeat (29) @(posedge clk);
    #1;
    chk("t4_pre_state", bus.current_state, 2);
    reset_n = 1'b0;
    ov_at_reset = ov_log.size();
    #1;
    chk_reset_outputs("t4_rst");
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t4_no_done", done_log.size(), 0);
    chk("t4_no_ov", ov_log.size(), ov_at_reset);
    do_start(8, 8, 1'b0);
    run_frame(0, 1, 200);
    chk("t4_nwin", win_log.size(), 36);
    chk("t4_nov", ov_log.size(), 36);
    chk("t4_nacc", n_acc, 64);

    // Start held high through frame_done: restart one cycle later
    bus.pixel_in_valid = 1'b1;
    do_start(3, 3, 1'b1);
    run_frame(0, 2, 100);
    bus.start = 1'b0;
    chk("t5_ndone", done_log.size(), 2);
    chk("t5_done0", done_log[0], 13);
    chk("t5_done1", done_log[1], 27);
    chk("t5_st13", st_at[13], 0);
    chk("t5_st14", st_at[14], 0);
    chk("t5_st15", st_at[15], 1);
    chk("t5_nwin", win_log.size(), 2);

    // Cycle-by-cycle invariants gathered across all frames
    chk("acc_clear_inv", ac_bad, 0);
    chk("out_valid_delay", ov_bad, 0);
    chk("busy_vs_state", busy_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
